m_fetch_queue: RTL and testbench

M_FETCH_QUEUE -- requirements
Module: m_fetch_queue

---
 rtl/m_fetch_queue_if.sv | 32 +++
 rtl/m_fetch_queue.sv | 105 ++++++++++
 tb/tb_m_fetch_queue.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/m_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : m_fetch_queue_if
// Function : Handshake, instruction-memory and status bundle for m_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
interface m_fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    logic                            w_ce;
    logic                            w_redirect;
    logic [31:0]                     w_redirect_pc;
    logic [11:0]                     w_imem_addr;
    logic [31:0]                     w_imem_rdata;
    logic                            w_valid;
    logic                            w_ready;
    logic [31:0]                     w_pc;
    logic [31:0]                     w_instr;
    logic [$clog2(DEPTH+1)-1:0]      w_count;
    logic                            w_halted;

    // master: the fetch queue itself; slave: the core/memory environment
    modport master (
        input  w_ce, w_redirect, w_redirect_pc, w_imem_rdata, w_ready,
        output w_imem_addr, w_valid, w_pc, w_instr, w_count, w_halted
    );
    modport slave (
        output w_ce, w_redirect, w_redirect_pc, w_imem_rdata, w_ready,
        input  w_imem_addr, w_valid, w_pc, w_instr, w_count, w_halted
    );
endinterface
`default_nettype wire

// File: rtl/m_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : m_fetch_queue
// Function : Instruction fetch queue with redirect flush and halt detection.
//            Optional macro FETCHQ_BYPASS_EN forwards a fetch straight to the
//            head outputs when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module m_fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] HALT_INSTR = 32'h000f0033
) (
    input  wire logic        w_clk,
    input  wire logic        w_rst,
    m_fetch_queue_if.master  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             halted_q;
    logic [31:0]      mem_pc_q    [DEPTH];
    logic [31:0]      mem_instr_q [DEPTH];

    logic w_empty;
    logic w_fetch_ok;
    logic w_bypass;
    logic w_valid_int;
    logic w_pop;
    logic w_push;
    logic w_store;
    logic w_deq;

    assign w_empty    = (count_q == '0);
    assign w_fetch_ok = bus.w_ce & ~bus.w_redirect & ~halted_q;

`ifdef FETCHQ_BYPASS_EN
    assign w_bypass = w_empty & w_fetch_ok;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid_int = ~w_empty | w_bypass;
    assign w_pop       = bus.w_ce & w_valid_int & bus.w_ready & ~bus.w_redirect;
    assign w_push      = w_fetch_ok & ((count_q < CNT_W'(DEPTH)) | w_pop);
    // A bypassed fetch that is accepted the same cycle never touches storage
    assign w_store     = w_push & ~(w_bypass & w_pop);
    assign w_deq       = w_pop & ~w_empty;

    always_comb begin
        count_d = count_q;
        case ({w_store, w_deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            pc_q     <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else if (bus.w_ce) begin
            if (bus.w_redirect) begin
                pc_q     <= bus.w_redirect_pc;
                head_q   <= '0;
                tail_q   <= '0;
                count_q  <= '0;
                halted_q <= 1'b0;
            end else begin
                count_q <= count_d;
                if (w_store) tail_q <= tail_q + PTR_W'(1);
                if (w_deq)   head_q <= head_q + PTR_W'(1);
                // The halt word is queued, but pc parks on its address
                if (w_push) begin
                    if (bus.w_imem_rdata == HALT_INSTR) halted_q <= 1'b1;
                    else                                pc_q     <= pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst && w_store) begin
            mem_pc_q[tail_q]    <= pc_q;
            mem_instr_q[tail_q] <= bus.w_imem_rdata;
        end
    end

    assign bus.w_imem_addr = pc_q[13:2];
    assign bus.w_valid     = w_valid_int;
    assign bus.w_count     = count_q;
    assign bus.w_halted    = halted_q;
    assign bus.w_pc        = !w_empty ? mem_pc_q[head_q]    : (w_bypass ? pc_q : 32'h0);
    assign bus.w_instr     = !w_empty ? mem_instr_q[head_q] : (w_bypass ? bus.w_imem_rdata : 32'h0);
endmodule
`default_nettype wire

// File: tb/tb_m_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_fetch_queue
// Function : Directed self-checking bench for m_fetch_queue against a
//            queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_PC   = 32'h0;
    localparam logic [31:0] HALT     = 32'h000f0033;
`ifdef FETCHQ_BYPASS_EN
    localparam bit          BYP      = 1'b1;
`else
    localparam bit          BYP      = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    m_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    m_fetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_PC   (RST_PC),
        .HALT_INSTR (HALT)
    ) dut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (bus)
    );

    logic [31:0] imem [0:4095];
    assign bus.w_imem_rdata = imem[bus.w_imem_addr];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of fetched {pc, instr} pairs plus fetch pc and halt flag
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        mq [$];
    logic [31:0] mpc;
    bit          mhalt;
    bit          mok = 1'b0;

    always @(negedge clk) begin
        logic [31:0] inow, epc, ein;
        bit          ev, pop, push;
        int          n;
        n    = mq.size();
        inow = imem[mpc[13:2]];
        if (n > 0) begin
            ev = 1'b1; epc = mq[0].pc; ein = mq[0].instr;
        end else if (BYP && bus.w_ce && !bus.w_redirect && !mhalt) begin
            ev = 1'b1; epc = mpc; ein = inow;
        end else begin
            ev = 1'b0; epc = 32'h0; ein = 32'h0;
        end
        pop  = bus.w_ce && ev && bus.w_ready && !bus.w_redirect;
        push = bus.w_ce && !bus.w_redirect && !mhalt && (n < DEPTH || pop);
        if (mok) begin
            chk("valid",     32'(bus.w_valid),     32'(ev));
            chk("pc",        bus.w_pc,             epc);
            chk("instr",     bus.w_instr,          ein);
            chk("count",     32'(bus.w_count),     32'(n));
            chk("halted",    32'(bus.w_halted),    32'(mhalt));
            chk("imem_addr", 32'(bus.w_imem_addr), {20'h0, mpc[13:2]});
        end
        if (rst) begin
            mq.delete(); mpc = RST_PC; mhalt = 1'b0; mok = 1'b1;
        end else if (mok && bus.w_ce) begin
            if (bus.w_redirect) begin
                mq.delete(); mpc = bus.w_redirect_pc; mhalt = 1'b0;
            end else begin
                if (pop && n > 0) void'(mq.pop_front());
                if (push) begin
                    if (!(BYP && n == 0 && pop)) mq.push_back('{pc: mpc, instr: inow});
                    if (inow == HALT) mhalt = 1'b1;
                    else              mpc   = mpc + 32'd4;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.w_ce = 1'b1; bus.w_redirect = 1'b0; bus.w_redirect_pc = 32'h0; bus.w_ready = 1'b1;
        for (int i = 0; i < 4096; i++) imem[i] = 32'(i + 1);

        // Reset, then continuous streaming with ready high
        cyc(); cyc();
        @(negedge clk);
        chk("lit_rst_count", 32'(bus.w_count), 32'd0);
        chk("lit_rst_valid", 32'(bus.w_valid), 32'(BYP));
        cyc(); rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("lit_s1_pc0", bus.w_pc, BYP ? 32'h4 : 32'h0);
        chk("lit_s1_in0", bus.w_instr, BYP ? 32'd2 : 32'd1);
        cyc();
        @(negedge clk);
        chk("lit_s1_pc1", bus.w_pc, BYP ? 32'h8 : 32'h4);
        chk("lit_s1_cnt", 32'(bus.w_count), BYP ? 32'd0 : 32'd1);

        // Saturate with ready low, then drain one per cycle while staying full
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; bus.w_ready = 1'b0;
        repeat (6) cyc();
        @(negedge clk);
        chk("lit_s2_count", 32'(bus.w_count), 32'd4);
        chk("lit_s2_addr",  32'(bus.w_imem_addr), 32'd4);
        cyc(); bus.w_ready = 1'b1;
        @(negedge clk);
        chk("lit_s2_pc0", bus.w_pc, 32'h0);
        cyc();
        @(negedge clk);
        chk("lit_s2_pc1", bus.w_pc, 32'h4);
        chk("lit_s2_cnt1", 32'(bus.w_count), 32'd4);
        cyc();
        @(negedge clk);
        chk("lit_s2_pc2", bus.w_pc, 32'h8);

        // Redirect from a full queue
        cyc(); bus.w_ready = 1'b0; bus.w_redirect = 1'b1; bus.w_redirect_pc = 32'h40;
        @(negedge clk);
        chk("lit_s3_full", 32'(bus.w_count), 32'd4);
        cyc(); bus.w_redirect = 1'b0; bus.w_ready = 1'b1;
        @(negedge clk);
        chk("lit_s3_n1_cnt", 32'(bus.w_count), 32'd0);
        chk("lit_s3_n1_val", 32'(bus.w_valid), 32'(BYP));
        chk("lit_s3_n1_pc",  bus.w_pc, BYP ? 32'h40 : 32'h0);
        cyc();
        @(negedge clk);
        chk("lit_s3_n2_val", 32'(bus.w_valid), 32'd1);
        chk("lit_s3_n2_pc",  bus.w_pc, BYP ? 32'h44 : 32'h40);
        chk("lit_s3_n2_in",  bus.w_instr, BYP ? 32'd18 : 32'd17);

        // Halt instruction at word 2
        cyc(); imem[2] = HALT; rst = 1'b1; bus.w_ready = 1'b0;
        cyc(); rst = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("lit_s4_count",  32'(bus.w_count), 32'd3);
        chk("lit_s4_halted", 32'(bus.w_halted), 32'd1);
        chk("lit_s4_addr",   32'(bus.w_imem_addr), 32'd2);
        cyc(); cyc();
        @(negedge clk);
        chk("lit_s4_hold", 32'(bus.w_count), 32'd3);
        cyc(); bus.w_redirect = 1'b1; bus.w_redirect_pc = 32'h0;
        cyc(); bus.w_redirect = 1'b0; imem[2] = 32'd3;
        @(negedge clk);
        chk("lit_s4_unhalt", 32'(bus.w_halted), 32'd0);
        chk("lit_s4_flush",  32'(bus.w_count), 32'd0);

        // Clock-enable freeze mid-stream, then reset while full
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        cyc(); cyc();
        bus.w_ce = 1'b0; bus.w_ready = 1'b1; bus.w_redirect = 1'b1; bus.w_redirect_pc = 32'h80;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lit_s5_ce_cnt",  32'(bus.w_count), 32'd2);
            chk("lit_s5_ce_pc",   bus.w_pc, 32'h0);
            chk("lit_s5_ce_addr", 32'(bus.w_imem_addr), 32'd2);
            cyc();
        end
        bus.w_ce = 1'b1; bus.w_redirect = 1'b0; bus.w_ready = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("lit_s5_full", 32'(bus.w_count), 32'd4);
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("lit_s5_rst_cnt",  32'(bus.w_count), 32'd0);
        chk("lit_s5_rst_addr", 32'(bus.w_imem_addr), {20'h0, RST_PC[13:2]});
        bus.w_ready = 1'b1;
        repeat (4) cyc();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
